// File: rtl/rib_master_arb.sv
// ---------------------------------------------------------------------------
// rib_master_arb
//
// Purpose:
//   Connects NUM_M RIB masters to one shared RIB slave (ITCM, SDRAM or a
//   peripheral bus). One master at a time is selected for the address phase.
//   The selection policy is fixed priority or round-robin. A master that is
//   selected but not yet granted keeps the selection until its address
//   handshake completes or until it drops its request. The index of every
//   accepted master is written into an in-order ID FIFO. The FIFO head
//   routes each slave response back to the master that issued the request.
//
// Parameters:
//   NUM_M     - number of masters (2..8)
//   RR_MODE   - 0: fixed priority, highest index wins; 1: round-robin
//   MAX_OUTST - depth of the outstanding-response ID FIFO (1..8)
//
// Ports:
//   i_clk, i_rstn                  - clock, asynchronous active-low reset
//   i_ribm_addr/wrcs/mask/wdata    - packed master request fields
//   i_ribm_req                     - per-master request
//   o_ribm_gnt                     - per-master grant (one-hot or zero)
//   o_ribm_rsp                     - per-master response valid (one-hot or zero)
//   i_ribm_rdy                     - per-master response ready
//   o_ribm_rdata                   - slave read data broadcast to all masters
//   o_ribs_addr/wrcs/mask/wdata    - fields of the selected master
//   o_ribs_req, i_ribs_gnt         - slave address handshake
//   i_ribs_rsp, o_ribs_rdy         - slave response handshake
//   i_ribs_rdata                   - slave read data
//   o_outst_cnt                    - number of responses still owed
// ---------------------------------------------------------------------------
module rib_master_arb #(
    parameter int NUM_M     = 2,
    parameter int RR_MODE   = 0,
    parameter int MAX_OUTST = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [32*NUM_M-1:0]   i_ribm_addr,
    input  logic [NUM_M-1:0]      i_ribm_wrcs,
    input  logic [4*NUM_M-1:0]    i_ribm_mask,
    input  logic [32*NUM_M-1:0]   i_ribm_wdata,
    output logic [32*NUM_M-1:0]   o_ribm_rdata,
    input  logic [NUM_M-1:0]      i_ribm_req,
    output logic [NUM_M-1:0]      o_ribm_gnt,
    output logic [NUM_M-1:0]      o_ribm_rsp,
    input  logic [NUM_M-1:0]      i_ribm_rdy,
    output logic [31:0]           o_ribs_addr,
    output logic                  o_ribs_wrcs,
    output logic [3:0]            o_ribs_mask,
    output logic [31:0]           o_ribs_wdata,
    input  logic [31:0]           i_ribs_rdata,
    output logic                  o_ribs_req,
    input  logic                  i_ribs_gnt,
    input  logic                  i_ribs_rsp,
    output logic                  o_ribs_rdy,
    output logic [3:0]            o_outst_cnt
);

    localparam int IDW  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int PTRW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    typedef enum logic {
        LOCK_OPEN,
        LOCK_HELD
    } lock_state_t;

    lock_state_t lock_state, lock_next;

    logic [IDW-1:0]  sel_id;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  arb_id;
    logic [IDW-1:0]  sel;
    logic            sel_req;
    logic            addr_hs;
    logic            rsp_hs;

    logic [IDW-1:0]  id_mem [MAX_OUTST];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [3:0]      count;
    logic            fifo_full;
    logic            fifo_empty;
    logic [IDW-1:0]  head_id;

    // Free-running arbitration among the current requesters. It is used
    // whenever no lock is held, or when the locked master has dropped its
    // request.
    always_comb begin
        arb_id = '0;
        if (RR_MODE == 0) begin
            for (int k = 0; k < NUM_M; k++) begin
                if (i_ribm_req[k]) begin
                    arb_id = IDW'(k);
                end
            end
        end else begin
            for (int k = NUM_M; k >= 1; k--) begin
                if (i_ribm_req[(int'(rr_ptr) + k) % NUM_M]) begin
                    arb_id = IDW'((int'(rr_ptr) + k) % NUM_M);
                end
            end
        end
    end

    // Lock state register. The lock stores the master that is waiting for a grant.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            lock_state <= LOCK_OPEN;
            sel_id     <= '0;
        end else begin
            lock_state <= lock_next;
            if (lock_next == LOCK_HELD) begin
                sel_id <= sel;
            end
        end
    end

    // The lock is held while the selected master requests without a
    // completed handshake. A full FIFO also counts as "no handshake".
    always_comb begin
        lock_next = LOCK_OPEN;
        if (sel_req && !addr_hs) begin
            lock_next = LOCK_HELD;
        end
    end

    // The lock output picks the selected master. A lock is honoured only
    // while its owner still requests. This lets arbitration resume in the
    // cycle the request drops.
    always_comb begin
        sel = arb_id;
        if (lock_state == LOCK_HELD && i_ribm_req[sel_id]) begin
            sel = sel_id;
        end
    end

    assign sel_req    = i_ribm_req[sel];
    assign fifo_full  = (count == 4'(MAX_OUTST));
    assign fifo_empty = (count == 4'd0);
    assign o_ribs_req = sel_req & ~fifo_full;
    assign addr_hs    = o_ribs_req & i_ribs_gnt;
    assign head_id    = id_mem[rd_ptr];
    assign rsp_hs     = i_ribs_rsp & o_ribs_rdy;
    assign o_outst_cnt = count;
    assign o_ribm_rdata = {NUM_M{i_ribs_rdata}};

    // Slave-side field mux. All fields are zero when nobody requests.
    always_comb begin
        o_ribs_addr  = '0;
        o_ribs_wrcs  = 1'b0;
        o_ribs_mask  = '0;
        o_ribs_wdata = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (sel_req && sel == IDW'(k)) begin
                o_ribs_addr  = i_ribm_addr[32*k +: 32];
                o_ribs_wrcs  = i_ribm_wrcs[k];
                o_ribs_mask  = i_ribm_mask[4*k +: 4];
                o_ribs_wdata = i_ribm_wdata[32*k +: 32];
            end
        end
    end

    // Grant goes back to the selected master. Response valid and ready go to
    // and from the FIFO head. A response while the FIFO is empty has no owner
    // and is ignored.
    always_comb begin
        o_ribm_gnt = '0;
        o_ribm_rsp = '0;
        o_ribs_rdy = 1'b0;
        if (addr_hs) begin
            o_ribm_gnt[sel] = 1'b1;
        end
        if (!fifo_empty) begin
            o_ribm_rsp[head_id] = i_ribs_rsp;
            o_ribs_rdy          = i_ribm_rdy[head_id];
        end
    end

    // The round-robin pointer moves only when an address is accepted. After
    // reset it points at the last master, so master 0 is searched first.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rr_ptr <= IDW'(NUM_M - 1);
        end else if (addr_hs) begin
            rr_ptr <= sel;
        end
    end

    // ID FIFO storage. The contents do not matter while the FIFO is empty,
    // so the storage has no reset.
    always_ff @(posedge i_clk) begin
        if (addr_hs) begin
            id_mem[wr_ptr] <= sel;
        end
    end

    // ID FIFO pointers and occupancy. A push and a pop in the same cycle
    // leave the count unchanged.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else begin
            if (addr_hs) begin
                wr_ptr <= (wr_ptr == PTRW'(MAX_OUTST - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (rsp_hs) begin
                rd_ptr <= (rd_ptr == PTRW'(MAX_OUTST - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (addr_hs && !rsp_hs) begin
                count <= count + 4'd1;
            end else if (rsp_hs && !addr_hs) begin
                count <= count - 4'd1;
            end
        end
    end

endmodule
